// File: rtl/axis_packet_buffer.sv
// AXI-Stream store-and-forward buffer with per-beat tstrb/tlast storage,
// cut-through or whole-packet release, and fill / packet-count status.
module axis_packet_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 0,
  parameter int LVL_W       = $clog2(DEPTH) + 1
) (
  input  logic                    axis_aclk,
  input  logic                    axis_aresetn,
  input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
  input  logic                    s01_axis_tvalid,
  input  logic                    s01_axis_tlast,
  output logic                    s01_axis_tready,
  output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
  output logic                    m01_axis_tvalid,
  output logic                    m01_axis_tlast,
  input  logic                    m01_axis_tready,
  output logic [LVL_W-1:0]        fill_level,
  output logic [LVL_W-1:0]        pkt_count,
  output logic                    overflow_cut
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = DATA_WIDTH / 8;
  localparam int EW = DATA_WIDTH + SW + 1;
  localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

  typedef enum logic {ST_IDLE, ST_CUT} cut_state_t;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] fill_q, fill_d, pkt_q, pkt_d;
  logic             tready_q, tready_d;
  logic             ovf_q, ovf_d;
  cut_state_t       state_q, state_d;

  logic             push, pop, tvalid, head_last, pkt_inc, pkt_dec;
  logic [EW-1:0]    head;

  // First-word-fall-through: the head entry is presented combinationally.
  assign head      = mem[rd_ptr_q];
  assign head_last = head[EW-1];
  assign push      = s01_axis_tvalid && tready_q;
  assign pop       = tvalid && m01_axis_tready;
  assign pkt_inc   = push && s01_axis_tlast;
  assign pkt_dec   = pop && head_last;

  always_ff @(posedge axis_aclk) begin
    if (push) begin
      mem[wr_ptr_q] <= {s01_axis_tlast, s01_axis_tstrb, s01_axis_tdata};
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    fill_d   = fill_q;
    if (push && !pop) begin
      fill_d = fill_q + LVL_W'(1);
    end else if (pop && !push) begin
      fill_d = fill_q - LVL_W'(1);
    end
    pkt_d = pkt_q;
    if (pkt_inc && !pkt_dec) begin
      pkt_d = pkt_q + LVL_W'(1);
    end else if (pkt_dec && !pkt_inc) begin
      pkt_d = pkt_q - LVL_W'(1);
    end
    tready_d = (fill_d < FULL);
    ovf_d    = ovf_q || (state_q == ST_IDLE && state_d == ST_CUT);
  end

  // Cut state: a packet longer than the buffer is forced out cut-through
  // until its tlast beat leaves, otherwise packet mode would deadlock.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (PACKET_MODE != 0 && fill_q == FULL && pkt_q == '0) state_d = ST_CUT;
      ST_CUT:  if (pkt_dec) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tvalid = 1'b0;
    if (fill_q != '0) begin
      tvalid = (PACKET_MODE == 0) || (pkt_q != '0) || (fill_q == FULL) ||
               (state_q == ST_CUT);
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      pkt_q    <= '0;
      tready_q <= 1'b0;
      ovf_q    <= 1'b0;
      state_q  <= ST_IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      pkt_q    <= pkt_d;
      tready_q <= tready_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
    end
  end

  assign s01_axis_tready = tready_q;
  assign m01_axis_tvalid = tvalid;
  assign m01_axis_tdata  = head[DATA_WIDTH-1:0];
  assign m01_axis_tstrb  = head[DATA_WIDTH+SW-1:DATA_WIDTH];
  assign m01_axis_tlast  = head_last;
  assign fill_level      = fill_q;
  assign pkt_count       = pkt_q;
  assign overflow_cut    = ovf_q;

endmodule
